// File: rtl/door_pkg.sv
// door_pkg: shared types and helpers for the door-motor controller.
//   door_state_t  - FSM state codes (6 and 7 are illegal)
//   DOOR_STATE_W  - width of the state code
//   cnt_w()       - counter width able to hold 0..max_val (at least 1 bit)
package door_pkg;

    localparam int unsigned DOOR_STATE_W = 3;

    typedef enum logic [DOOR_STATE_W-1:0] {
        CLOSED    = 3'd0,
        OPENING   = 3'd1,
        OPEN_HOLD = 3'd2,
        CLOSING   = 3'd3,
        STOPPED   = 3'd4,
        FAULT     = 3'd5
    } door_state_t;

    // Bits needed to represent 0..max_val; never returns 0 so vectors stay legal.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/door_if.sv
// door_if: sensor/motor bundle between the pin wrapper (master) and door_ctrl (slave).
//   ena, sen, se, la, lc, fault_clr : master -> slave
//   ma, mc, state, fault, rev_cnt   : slave -> master
// Parameter REV_W must match the rev_cnt width of the attached door_ctrl.
interface door_if import door_pkg::*; #(
    parameter int unsigned REV_W = 2
) ();

    logic                    ena;
    logic                    sen;
    logic                    se;
    logic                    la;
    logic                    lc;
    logic                    fault_clr;
    logic                    ma;
    logic                    mc;
    logic [DOOR_STATE_W-1:0] state;
    logic                    fault;
    logic [REV_W-1:0]        rev_cnt;

    modport master (
        output ena, sen, se, la, lc, fault_clr,
        input  ma, mc, state, fault, rev_cnt
    );

    modport slave (
        input  ena, sen, se, la, lc, fault_clr,
        output ma, mc, state, fault, rev_cnt
    );

endinterface

// File: rtl/door_debounce.sv
// door_debounce: 2-flop synchroniser followed by a stability filter.
// The output follows the synchronised input only after LEN consecutive
// samples that differ from the current output.
//   clk, rst_n : clock, async active-low reset
//   d_i        : raw asynchronous input
//   q_o        : filtered output (reset value 0)
module door_debounce import door_pkg::*; #(
    parameter int unsigned LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    localparam int unsigned       CNT_W    = cnt_w(LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

    logic             sync1_q, sync2_q;
    logic             q_q, q_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Synchroniser, filter count and filtered value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            q_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= d_i;
            sync2_q <= sync1_q;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any sample equal to the output restarts the run of differing samples
    always_comb begin
        q_d   = q_q;
        cnt_d = '0;
        if (sync2_q != q_q) begin
            if (cnt_q == CNT_LAST) begin
                q_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/door_ctrl.sv
// door_ctrl: door-motor controller with hold-open timer, motor-run timeout,
// obstruction reversal with a reversal limit, limit-switch conflict detection
// and a latched fault with explicit clear.
//   clk, rst_n    : clock, async active-low reset
//   door (slave)  : ena/sen/se/la/lc/fault_clr in; ma/mc/state/fault/rev_cnt out
// Optional: define DOOR_DEBOUNCE_EN to filter sen/se/la/lc through door_debounce.
module door_ctrl import door_pkg::*; #(
    parameter int unsigned HOLD_CYCLES   = 1000,
    parameter int unsigned MOTOR_TIMEOUT = 5000,
    parameter int unsigned MAX_REVERSALS = 3,
    parameter int unsigned DEBOUNCE_LEN  = 4
) (
    input logic   clk,
    input logic   rst_n,
    door_if.slave door
);

    localparam int unsigned HOLD_W = cnt_w(HOLD_CYCLES - 1);
    localparam int unsigned TMR_W  = cnt_w(MOTOR_TIMEOUT - 1);
    localparam int unsigned REV_W  = cnt_w(MAX_REVERSALS);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(MOTOR_TIMEOUT - 1);
    localparam logic [REV_W-1:0]  REV_MAX   = REV_W'(MAX_REVERSALS);

    localparam logic [DOOR_STATE_W-1:0] S_CLOSED    = DOOR_STATE_W'(CLOSED);
    localparam logic [DOOR_STATE_W-1:0] S_OPENING   = DOOR_STATE_W'(OPENING);
    localparam logic [DOOR_STATE_W-1:0] S_OPEN_HOLD = DOOR_STATE_W'(OPEN_HOLD);
    localparam logic [DOOR_STATE_W-1:0] S_CLOSING   = DOOR_STATE_W'(CLOSING);
    localparam logic [DOOR_STATE_W-1:0] S_STOPPED   = DOOR_STATE_W'(STOPPED);
    localparam logic [DOOR_STATE_W-1:0] S_FAULT     = DOOR_STATE_W'(FAULT);

    // Reject parameter values the counters cannot represent
    if (HOLD_CYCLES < 1 || MOTOR_TIMEOUT < 2 || DEBOUNCE_LEN < 1) begin : g_bad_param
        $error("door_ctrl: illegal parameter value");
    end

    logic sen_f, se_f, la_f, lc_f;

`ifdef DOOR_DEBOUNCE_EN
    door_debounce #(.LEN(DEBOUNCE_LEN)) u_db_sen (.clk(clk), .rst_n(rst_n), .d_i(door.sen), .q_o(sen_f));
    door_debounce #(.LEN(DEBOUNCE_LEN)) u_db_se  (.clk(clk), .rst_n(rst_n), .d_i(door.se),  .q_o(se_f));
    door_debounce #(.LEN(DEBOUNCE_LEN)) u_db_la  (.clk(clk), .rst_n(rst_n), .d_i(door.la),  .q_o(la_f));
    door_debounce #(.LEN(DEBOUNCE_LEN)) u_db_lc  (.clk(clk), .rst_n(rst_n), .d_i(door.lc),  .q_o(lc_f));
`else
    assign sen_f = door.sen;
    assign se_f  = door.se;
    assign la_f  = door.la;
    assign lc_f  = door.lc;
`endif

    logic [DOOR_STATE_W-1:0] state_q, state_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [REV_W-1:0]        rev_q, rev_d;
    logic                    conflict;
    logic                    se_stops;

    assign conflict = la_f & lc_f;
    assign se_stops = se_f & ((state_q == S_OPENING) || (state_q == S_OPEN_HOLD) ||
                              (state_q == S_CLOSING));

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLOSED;
            hold_q  <= '0;
            tmr_q   <= '0;
            rev_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tmr_q   <= tmr_d;
            rev_q   <= rev_d;
        end
    end

    // Next state; everything holds while ena is low. The motor timer is
    // cleared on every transition into OPENING/CLOSING, and limit switches
    // are tested before the timeout so they win on the final cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tmr_d   = tmr_q;
        rev_d   = rev_q;
        if (door.ena) begin
            if (conflict && (state_q != S_FAULT)) begin
                state_d = S_FAULT;
            end else if (se_stops) begin
                state_d = S_STOPPED;
            end else begin
                case (state_q)
                    S_CLOSED: begin
                        if (sen_f && !se_f) begin
                            state_d = S_OPENING;
                            tmr_d   = '0;
                        end
                    end
                    S_OPENING: begin
                        if (la_f) begin
                            state_d = S_OPEN_HOLD;
                            hold_d  = HOLD_LOAD;
                        end else if (tmr_q == TMR_LAST) begin
                            state_d = S_FAULT;
                        end else begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                    end
                    S_OPEN_HOLD: begin
                        if (sen_f) begin
                            hold_d = HOLD_LOAD;
                        end else if (hold_q == '0) begin
                            state_d = S_CLOSING;
                            tmr_d   = '0;
                        end else begin
                            hold_d = hold_q - HOLD_W'(1);
                        end
                    end
                    S_CLOSING: begin
                        if (lc_f) begin
                            state_d = S_CLOSED;
                            rev_d   = '0;
                        end else if (sen_f) begin
                            if (rev_q < REV_MAX) begin
                                state_d = S_OPENING;
                                tmr_d   = '0;
                                rev_d   = rev_q + REV_W'(1);
                            end else begin
                                state_d = S_FAULT;
                            end
                        end else if (tmr_q == TMR_LAST) begin
                            state_d = S_FAULT;
                        end else begin
                            tmr_d = tmr_q + TMR_W'(1);
                        end
                    end
                    S_STOPPED: begin
                        if (!se_f) begin
                            state_d = S_OPENING;
                            tmr_d   = '0;
                        end
                    end
                    S_FAULT: begin
                        if (door.fault_clr && !se_f && !conflict) begin
                            if (lc_f) begin
                                state_d = S_CLOSED;
                                rev_d   = '0;
                            end else begin
                                state_d = S_OPENING;
                                tmr_d   = '0;
                            end
                        end
                    end
                    default: state_d = S_FAULT;
                endcase
            end
        end
    end

    // Motor drives are decoded from state and gated by ena; the state decode
    // makes ma/mc mutually exclusive and lets reset drop them immediately.
    assign door.ma      = door.ena & (state_q == S_OPENING);
    assign door.mc      = door.ena & (state_q == S_CLOSING);
    assign door.fault   = (state_q == S_FAULT);
    assign door.state   = state_q;
    assign door.rev_cnt = rev_q;

endmodule

// File: tb/tb_door_ctrl.sv
// tb_door_ctrl: directed scoreboard bench for door_ctrl
// (HOLD_CYCLES=4, MOTOR_TIMEOUT=8, MAX_REVERSALS=2, debounce off).
// Each step pushes the expected {ma,mc,state,fault,rev_cnt} and pops it once
// the DUT output is sampled 1 time unit after the clock edge.
module tb_door_ctrl;
    import door_pkg::*;

    localparam int unsigned H = 4;
    localparam int unsigned T = 8;
    localparam int unsigned R = 2;

    logic clk = 1'b0;
    logic rst_n;

    door_if #(.REV_W(2)) dif ();

    door_ctrl #(
        .HOLD_CYCLES  (H),
        .MOTOR_TIMEOUT(T),
        .MAX_REVERSALS(R),
        .DEBOUNCE_LEN (4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .door (dif)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [7:0] e(input logic ma, input logic mc, input logic [2:0] st,
                                     input logic flt, input logic [1:0] rev);
        return {ma, mc, st, flt, rev};
    endfunction

    task automatic compare_pop();
        exp_t       x;
        logic [7:0] o;
        o = {dif.ma, dif.mc, dif.state, dif.fault, dif.rev_cnt};
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %b, no expectation queued", o);
        end else begin
            x = sb_q.pop_front();
            assert (o === x.val) else begin
                n_err++;
                $error("FAIL %s: observed {ma,mc,st,flt,rev}=%b expected %b", x.tag, o, x.val);
            end
        end
    endtask

    // Expectation for the state after the next rising edge
    task automatic cyc(input string tag, input logic [7:0] v);
        sb_q.push_back('{tag, v});
        @(posedge clk);
        #1;
        compare_pop();
    endtask

    // Expectation for the combinational/asynchronous response right now
    task automatic now(input string tag, input logic [7:0] v);
        sb_q.push_back('{tag, v});
        #1;
        compare_pop();
    endtask

    // From OPENING: hit la, sit in OPEN_HOLD for H cycles, land in CLOSING
    task automatic to_closing(input string tag, input logic [1:0] rev);
        dif.la = 1'b1;
        cyc({tag, "_hold_enter"}, e(0, 0, 3'd2, 0, rev));
        dif.la = 1'b0;
        repeat (H - 1) cyc({tag, "_hold"}, e(0, 0, 3'd2, 0, rev));
        cyc({tag, "_closing"}, e(0, 1, 3'd3, 0, rev));
    endtask

    initial begin
        rst_n         = 1'b0;
        dif.ena       = 1'b1;
        dif.sen       = 1'b0;
        dif.se        = 1'b0;
        dif.la        = 1'b0;
        dif.lc        = 1'b0;
        dif.fault_clr = 1'b0;
        #12;
        now("reset", e(0, 0, 3'd0, 0, 2'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("idle", e(0, 0, 3'd0, 0, 2'd0));

        // se in CLOSED blocks opening
        dif.sen = 1'b1;
        dif.se  = 1'b1;
        cyc("se_blocks_open", e(0, 0, 3'd0, 0, 2'd0));
        dif.se  = 1'b0;

        // Normal cycle
        cyc("norm_open", e(1, 0, 3'd1, 0, 2'd0));
        dif.sen = 1'b0;
        cyc("norm_opening", e(1, 0, 3'd1, 0, 2'd0));
        to_closing("norm", 2'd0);
        dif.lc = 1'b1;
        cyc("norm_closed", e(0, 0, 3'd0, 0, 2'd0));
        dif.lc = 1'b0;

        // Opening timeout: ma high exactly T cycles
        dif.sen = 1'b1;
        cyc("to_open", e(1, 0, 3'd1, 0, 2'd0));
        dif.sen = 1'b0;
        repeat (T - 1) cyc("to_opening", e(1, 0, 3'd1, 0, 2'd0));
        cyc("to_fault", e(0, 0, 3'd5, 1, 2'd0));
        dif.fault_clr = 1'b1;
        dif.lc        = 1'b1;
        cyc("to_clr_closed", e(0, 0, 3'd0, 0, 2'd0));
        dif.fault_clr = 1'b0;
        dif.lc        = 1'b0;

        // Reversal limit
        dif.sen = 1'b1;
        cyc("rev_open", e(1, 0, 3'd1, 0, 2'd0));
        dif.sen = 1'b0;
        to_closing("rev0", 2'd0);
        dif.sen = 1'b1;
        cyc("rev_1", e(1, 0, 3'd1, 0, 2'd1));
        dif.sen = 1'b0;
        to_closing("rev1", 2'd1);
        dif.sen = 1'b1;
        cyc("rev_2", e(1, 0, 3'd1, 0, 2'd2));
        dif.sen = 1'b0;
        to_closing("rev2", 2'd2);
        dif.sen = 1'b1;
        cyc("rev_limit_fault", e(0, 0, 3'd5, 1, 2'd2));
        dif.sen       = 1'b0;
        dif.fault_clr = 1'b1;
        dif.lc        = 1'b1;
        cyc("rev_clr_closed", e(0, 0, 3'd0, 0, 2'd0));
        dif.fault_clr = 1'b0;
        dif.lc        = 1'b0;

        // Emergency stop mid-OPENING, then full timeout from the restart
        dif.sen = 1'b1;
        cyc("es_open", e(1, 0, 3'd1, 0, 2'd0));
        dif.sen = 1'b0;
        repeat (2) cyc("es_opening", e(1, 0, 3'd1, 0, 2'd0));
        dif.se = 1'b1;
        cyc("es_stopped", e(0, 0, 3'd4, 0, 2'd0));
        cyc("es_stopped_hold", e(0, 0, 3'd4, 0, 2'd0));
        dif.se = 1'b0;
        cyc("es_reopen", e(1, 0, 3'd1, 0, 2'd0));
        repeat (T - 1) cyc("es_timer_restart", e(1, 0, 3'd1, 0, 2'd0));
        cyc("es_timeout_fault", e(0, 0, 3'd5, 1, 2'd0));
        dif.fault_clr = 1'b1;
        cyc("es_clr_opening", e(1, 0, 3'd1, 0, 2'd0));
        dif.fault_clr = 1'b0;

        // Limit-switch conflict in OPEN_HOLD; clear refused while it persists
        dif.la = 1'b1;
        cyc("lc_hold", e(0, 0, 3'd2, 0, 2'd0));
        dif.lc = 1'b1;
        cyc("conflict_fault", e(0, 0, 3'd5, 1, 2'd0));
        dif.fault_clr = 1'b1;
        cyc("conflict_clr_blocked", e(0, 0, 3'd5, 1, 2'd0));
        dif.la = 1'b0;
        cyc("conflict_clr_closed", e(0, 0, 3'd0, 0, 2'd0));
        dif.fault_clr = 1'b0;
        dif.lc        = 1'b0;

        // ena freeze mid-CLOSING: timer must resume where it stopped
        dif.sen = 1'b1;
        cyc("ena_open", e(1, 0, 3'd1, 0, 2'd0));
        dif.sen = 1'b0;
        to_closing("ena", 2'd0);
        repeat (2) cyc("ena_closing", e(0, 1, 3'd3, 0, 2'd0));
        dif.ena = 1'b0;
        now("ena_low_mc_off", e(0, 0, 3'd3, 0, 2'd0));
        repeat (3) cyc("ena_frozen", e(0, 0, 3'd3, 0, 2'd0));
        dif.ena = 1'b1;
        now("ena_high_mc_on", e(0, 1, 3'd3, 0, 2'd0));
        repeat (T - 3) cyc("ena_resume", e(0, 1, 3'd3, 0, 2'd0));
        cyc("ena_close_timeout", e(0, 0, 3'd5, 1, 2'd0));

        // Reset mid-motion drops outputs asynchronously
        dif.fault_clr = 1'b1;
        cyc("rst_opening", e(1, 0, 3'd1, 0, 2'd0));
        dif.fault_clr = 1'b0;
        cyc("rst_opening2", e(1, 0, 3'd1, 0, 2'd0));
        #2;
        rst_n = 1'b0;
        now("rst_async", e(0, 0, 3'd0, 0, 2'd0));
        #3;
        rst_n = 1'b1;
        cyc("rst_after", e(0, 0, 3'd0, 0, 2'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
